// File: rtl/bl_zone_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bl_zone_scheduler_if                                         |
// | Description : Valid/ready beat stream from the zone scheduler to the       |
// |               LED-driver sink (one zone value per beat).                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface bl_zone_scheduler_if #(
    parameter int DW = 8,
    parameter int AW = 9
);
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic [AW-1:0] tx_idx;
    logic          tx_last;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_idx,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_idx,
        input  tx_last,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/bl_zone_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bl_zone_scheduler                                            |
// | Description : Frame-level backlight controller. Captures zone values into  |
// |               a ping-pong buffer, aligns gray_mode to frame boundaries and |
// |               streams each completed frame to the LED driver.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bl_zone_scheduler #(
    parameter int ZONES = 360,
    parameter int DW    = 8,
    parameter int AW    = 9
) (
    input  logic                i_pix_clk,
    input  logic                rst_n,
    input  logic                zone_vld,
    input  logic [AW-1:0]       zone_idx,
    input  logic [DW-1:0]       zone_data,
    input  logic                frame_sync,
    input  logic [1:0]          mode_req,
    output logic [1:0]          gray_mode,
    output logic                busy,
    output logic                err_drop,
    output logic                err_ovr,
    output logic                err_idx,
    bl_zone_scheduler_if.master tx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_zones = AW'(ZONES);
    localparam logic [AW-1:0] c_last  = AW'(ZONES - 1);

    state_t        state_q, state_d;
    logic          frame_sync_q;
    logic [1:0]    gray_mode_q, gray_mode_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          rd_ok_q, rd_ok_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic [AW-1:0] tx_idx_q, tx_idx_d;
    logic          err_drop_q, err_drop_d;
    logic          err_ovr_q, err_ovr_d;
    logic          err_idx_q, err_idx_d;

    // Two frame banks; capture always targets wbank, the stream reads rbank.
    logic [DW-1:0] bank_q [2][ZONES];

    logic          sync_e;
    logic          zone_ok;
    logic          wr_en;
    logic [AW-1:0] cnt_post;
    logic          busy_w;
    logic          beat;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_data;

    assign sync_e   = frame_sync & ~frame_sync_q;
    assign zone_ok  = (zone_idx < c_zones);
    assign wr_en    = zone_vld & zone_ok;
    // A write on the boundary cycle still counts toward the closing frame.
    assign cnt_post = (wr_en && (wr_cnt_q != c_zones)) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    assign busy_w   = (state_q != ST_IDLE);
    assign beat     = tx_valid_q & tx.tx_ready;
    assign idx_inc  = tx_idx_q + 1'b1;
    // LOAD fetches zone 0; SEND prefetches the next zone, never past the last one.
    assign rd_idx   = ((state_q == ST_SEND) && (tx_idx_q < c_last)) ? idx_inc : '0;
    assign rd_data  = bank_q[rbank_q][rd_idx];

    // Zone capture into the write bank; bank contents survive reset.
    always_ff @(posedge i_pix_clk) begin
        if (rst_n && wr_en) begin
            bank_q[wbank_q][zone_idx] <= zone_data;
        end
    end

    // Next-state, frame-boundary and stream decisions.
    always_comb begin
        state_d     = state_q;
        gray_mode_d = gray_mode_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wr_cnt_d    = cnt_post;
        rd_ok_d     = rd_ok_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        tx_data_d   = tx_data_q;
        tx_idx_d    = tx_idx_q;
        err_drop_d  = 1'b0;
        err_ovr_d   = 1'b0;
        err_idx_d   = zone_vld & ~zone_ok;

        case (state_q)
            ST_LOAD: begin
                tx_idx_d   = '0;
                tx_data_d  = rd_data;
                tx_last_d  = (c_last == '0);
                tx_valid_d = rd_ok_q;
                state_d    = rd_ok_q ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                if (beat) begin
                    if (tx_last_q) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        tx_idx_d  = idx_inc;
                        tx_data_d = rd_data;
                        tx_last_d = (idx_inc == c_last);
                    end
                end
            end
            default: begin
            end
        endcase

        // Boundary: only an idle streamer with a complete bank triggers a swap.
        if (sync_e) begin
            gray_mode_d = mode_req;
            wr_cnt_d    = '0;
            if (busy_w) begin
                err_ovr_d = 1'b1;
            end else if (cnt_post != c_zones) begin
                err_drop_d = 1'b1;
            end else begin
                rbank_d = wbank_q;
                wbank_d = ~wbank_q;
                rd_ok_d = 1'b1;
                state_d = ST_LOAD;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_pix_clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            frame_sync_q <= 1'b0;
            gray_mode_q  <= 2'b00;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            wr_cnt_q     <= '0;
            rd_ok_q      <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            tx_data_q    <= '0;
            tx_idx_q     <= '0;
            err_drop_q   <= 1'b0;
            err_ovr_q    <= 1'b0;
            err_idx_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_sync_q <= frame_sync;
            gray_mode_q  <= gray_mode_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_ok_q      <= rd_ok_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
            tx_data_q    <= tx_data_d;
            tx_idx_q     <= tx_idx_d;
            err_drop_q   <= err_drop_d;
            err_ovr_q    <= err_ovr_d;
            err_idx_q    <= err_idx_d;
        end
    end

    assign gray_mode   = gray_mode_q;
    assign busy        = busy_w;
    assign err_drop    = err_drop_q;
    assign err_ovr     = err_ovr_q;
    assign err_idx     = err_idx_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_last  = tx_last_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_idx   = tx_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_bl_zone_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bl_zone_scheduler                                         |
// | Description : Randomized bench for bl_zone_scheduler with a frame-level    |
// |               reference model and per-cycle output comparison.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bl_zone_scheduler;
    localparam int ZONES = 360;
    localparam int DW    = 8;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          zone_vld;
    logic [AW-1:0] zone_idx;
    logic [DW-1:0] zone_data;
    logic          frame_sync;
    logic [1:0]    mode_req;
    logic [1:0]    gray_mode;
    logic          busy, err_drop, err_ovr, err_idx;

    bl_zone_scheduler_if #(.DW(DW), .AW(AW)) tx_if ();

    bl_zone_scheduler #(.ZONES(ZONES), .DW(DW), .AW(AW)) dut (
        .i_pix_clk  (clk),
        .rst_n      (rst_n),
        .zone_vld   (zone_vld),
        .zone_idx   (zone_idx),
        .zone_data  (zone_data),
        .frame_sync (frame_sync),
        .mode_req   (mode_req),
        .gray_mode  (gray_mode),
        .busy       (busy),
        .err_drop   (err_drop),
        .err_ovr    (err_ovr),
        .err_idx    (err_idx),
        .tx         (tx_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view (capture array, snapshot of the sent frame).
    int         m_phase;        // 0 idle, 1 one-cycle lead-in, 2 streaming
    int         m_pos;
    int         m_cnt;
    bit         m_fs_prev;
    logic [1:0] m_gray;
    bit         m_edrop, m_eovr, m_eidx;
    logic [7:0] m_cap   [ZONES];
    logic [7:0] m_frame [ZONES];
    bit         chk_en = 1'b0;

    task automatic model_step();
        bit se;
        bit was_busy;
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_cnt = 0; m_fs_prev = 1'b0; m_gray = 2'b00;
            m_edrop = 1'b0; m_eovr = 1'b0; m_eidx = 1'b0;
            return;
        end
        se        = frame_sync && !m_fs_prev;
        m_fs_prev = frame_sync;
        was_busy  = (m_phase != 0);
        m_eidx    = zone_vld && (int'(zone_idx) >= ZONES);
        m_edrop   = 1'b0;
        m_eovr    = 1'b0;
        if (zone_vld && int'(zone_idx) < ZONES) begin
            m_cap[zone_idx] = zone_data;
            if (m_cnt < ZONES) m_cnt++;
        end
        if (m_phase == 1) begin
            m_phase = 2;
            m_pos   = 0;
        end else if (m_phase == 2 && tx_if.tx_ready) begin
            if (m_pos == ZONES - 1) m_phase = 0;
            else m_pos++;
        end
        if (se) begin
            m_gray = mode_req;
            if (was_busy) m_eovr = 1'b1;
            else if (m_cnt != ZONES) m_edrop = 1'b1;
            else begin
                for (int i = 0; i < ZONES; i++) m_frame[i] = m_cap[i];
                m_phase = 1;
            end
            m_cnt = 0;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_valid", tx_if.tx_valid, (m_phase == 2));
            check("busy", busy, (m_phase != 0));
            check("tx_last", tx_if.tx_last, (m_phase == 2 && m_pos == ZONES - 1));
            check("gray_mode", gray_mode, m_gray);
            check("err_drop", err_drop, m_edrop);
            check("err_ovr", err_ovr, m_eovr);
            check("err_idx", err_idx, m_eidx);
            if (m_phase == 2) begin
                check("tx_idx", tx_if.tx_idx, m_pos);
                check("tx_data", tx_if.tx_data, m_frame[m_pos]);
            end
        end
    end

    // Handshakes observed at the sink.
    int dut_beats = 0;
    always @(posedge clk) begin
        if (rst_n && tx_if.tx_valid && tx_if.tx_ready) dut_beats <= dut_beats + 1;
    end

    int ready_mode = 0;     // 0 always, 1 toggle, 2 random, 3 never
    int perm [ZONES];

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(bit v, int idx, int d, bit fs);
        zone_vld   = v;
        zone_idx   = idx[AW-1:0];
        zone_data  = d[DW-1:0];
        frame_sync = fs;
        case (ready_mode)
            0:       tx_if.tx_ready = 1'b1;
            1:       tx_if.tx_ready = ~tx_if.tx_ready;
            2:       tx_if.tx_ready = 1'($urandom_range(0, 1));
            default: tx_if.tx_ready = 1'b0;
        endcase
        tick();
    endtask

    task automatic write_frame(int n, bit rand_val, bit gaps, bit shuffle);
        int j, t, v;
        for (int i = 0; i < ZONES; i++) perm[i] = i;
        if (shuffle) begin
            for (int i = ZONES - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(1'b0, 0, 0, 1'b0);
            if (gaps && $urandom_range(0, 15) == 0) cyc(1'b1, 360 + int'($urandom_range(0, 151)), 0, 1'b0);
            v = rand_val ? int'($urandom_range(0, 255)) : (perm[i] & 255);
            cyc(1'b1, perm[i], v, 1'b0);
        end
    endtask

    task automatic do_sync();
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (busy && k < budget) begin
            cyc(1'b0, 0, 0, 1'b0);
            k++;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int first, last, cnt, lastidx, b0;
        rst_n = 1'b0; zone_vld = 1'b0; zone_idx = '0; zone_data = '0;
        frame_sync = 1'b0; mode_req = 2'b00; tx_if.tx_ready = 1'b1;

        // Reset values
        cyc(1'b0, 0, 0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);
        check("rst_tx_valid", tx_if.tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_idx", tx_if.tx_idx, 0);
        check("rst_tx_data", tx_if.tx_data, 0);
        check("rst_gray", gray_mode, 0);
        rst_n = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);

        // Full frame value=idx, ready high: latency and beat count
        write_frame(ZONES, 1'b0, 1'b0, 1'b1);
        mode_req = 2'b01;
        cyc(1'b0, 0, 0, 1'b1);
        check("t1_load_busy", busy, 1);
        check("t1_load_valid", tx_if.tx_valid, 0);
        check("t1_gray", gray_mode, 1);
        first = -1; last = -1; cnt = 0; lastidx = -1;
        for (int k = 2; k <= 400; k++) begin
            cyc(1'b0, 0, 0, (k < 4));
            if (tx_if.tx_valid) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
                if (tx_if.tx_last) lastidx = int'(tx_if.tx_idx);
            end
            if (k == 2) check("t1_first_data", tx_if.tx_data, 0);
            if (k == 100) check("t1_data_98", tx_if.tx_data, 98);
        end
        check("t1_first_cycle", first, 2);
        check("t1_last_cycle", last, 361);
        check("t1_beats", cnt, 360);
        check("t1_last_idx", lastidx, 359);
        check("t1_busy_after", busy, 0);

        // Incomplete frame is dropped
        write_frame(ZONES - 1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        check("t2_err_drop", err_drop, 1);
        check("t2_busy", busy, 0);
        cyc(1'b0, 0, 0, 1'b0);
        check("t2_err_drop_pulse", err_drop, 0);
        write_frame(ZONES, 1'b1, 1'b1, 1'b1);
        do_sync();
        wait_idle(500);

        // Toggling ready
        ready_mode = 1;
        write_frame(ZONES, 1'b1, 1'b0, 1'b1);
        b0 = dut_beats;
        do_sync();
        wait_idle(1000);
        check("t3_beats", dut_beats - b0, 360);

        // Overrun: second frame boundary while first is stalled
        ready_mode = 3;
        write_frame(ZONES, 1'b1, 1'b0, 1'b1);
        do_sync();
        write_frame(ZONES, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        check("t4_err_ovr", err_ovr, 1);
        check("t4_busy", busy, 1);
        cyc(1'b0, 0, 0, 1'b0);
        ready_mode = 0;
        b0 = dut_beats;
        wait_idle(1000);
        check("t4_beats", dut_beats - b0, 360);
        repeat (5) cyc(1'b0, 0, 0, 1'b0);
        check("t4_no_second", tx_if.tx_valid, 0);

        // Mode alignment and coincident last write
        mode_req = 2'b01;
        do_sync();
        write_frame(ZONES - 1, 1'b1, 1'b0, 1'b0);
        mode_req = 2'b10;
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        check("t5_gray_hold", gray_mode, 1);
        cyc(1'b1, 359, 8'hA5, 1'b1);
        check("t5_gray_new", gray_mode, 2);
        check("t5_no_drop", err_drop, 0);
        check("t5_busy", busy, 1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0);
        wait_idle(500);

        // Out-of-range index, then reset mid-stream
        cyc(1'b1, 400, 7, 1'b0);
        check("t6_err_idx", err_idx, 1);
        cyc(1'b0, 0, 0, 1'b0);
        check("t6_err_idx_pulse", err_idx, 0);
        write_frame(ZONES, 1'b1, 1'b0, 1'b1);
        do_sync();
        repeat (40) cyc(1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 0, 0, 1'b0);
        check("t6_rst_valid", tx_if.tx_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_idx", tx_if.tx_idx, 0);
        check("t6_rst_data", tx_if.tx_data, 0);
        check("t6_rst_gray", gray_mode, 0);
        rst_n = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        check("t6_post_rst_drop", err_drop, 1);
        cyc(1'b0, 0, 0, 1'b0);

        // Randomized frames with random ready and overlapping boundaries
        ready_mode = 2;
        for (int f = 0; f < 8; f++) begin
            mode_req = 2'($urandom_range(0, 3));
            write_frame(($urandom_range(0, 3) == 0) ? ZONES - 1 : ZONES, 1'b1, 1'b1, 1'b1);
            do_sync();
            if ($urandom_range(0, 1) == 1) wait_idle(2000);
        end
        wait_idle(2000);
        repeat (3) cyc(1'b0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
